// File: rtl/tetris_pkg.sv
// Board geometry, sweep states and score table shared by the tetris playfield blocks.
package tetris_pkg;

  localparam int unsigned BOARD_ROWS = 20;
  localparam int unsigned BOARD_COLS = 10;

  localparam logic [19:0] SCORE_0 = 20'd0;
  localparam logic [19:0] SCORE_1 = 20'd40;
  localparam logic [19:0] SCORE_2 = 20'd100;
  localparam logic [19:0] SCORE_3 = 20'd300;
  localparam logic [19:0] SCORE_4 = 20'd1200;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StChk,
    StWr,
    StFill,
    StDone
  } lc_state_e;

  function automatic logic [19:0] score_points(input logic [4:0] n_lines);
    logic [19:0] pts;
    case (n_lines)
      5'd0:    pts = SCORE_0;
      5'd1:    pts = SCORE_1;
      5'd2:    pts = SCORE_2;
      5'd3:    pts = SCORE_3;
      default: pts = SCORE_4;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/line_clear_ctl.sv
// Bottom-up sweep that drops full rows, compacts the survivors downward and zero-fills the top.
module line_clear_ctl #(
  parameter int unsigned BOARD_ROWS = tetris_pkg::BOARD_ROWS,
  parameter int unsigned BOARD_COLS = tetris_pkg::BOARD_COLS
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [4:0]            row_addr,
  input  logic [BOARD_COLS-1:0] row_rd_data,
  output logic                  row_wr_en,
  output logic [BOARD_COLS-1:0] row_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            lines,
  output logic [19:0]           points_add
);
  import tetris_pkg::*;

  localparam logic [4:0] LastRow = 5'(BOARD_ROWS - 1);
  localparam logic [4:0] MaxCnt  = 5'(BOARD_ROWS);

  lc_state_e             state_q, state_d;
  logic [4:0]            rd_ptr_q, rd_ptr_d;
  logic [4:0]            wr_ptr_q, wr_ptr_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [BOARD_COLS-1:0] row_buf_q, row_buf_d;
  logic                  advance;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      row_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      row_buf_q <= row_buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    row_buf_d = row_buf_q;
    advance   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          rd_ptr_d = LastRow;
          wr_ptr_d = LastRow;
          cnt_d    = '0;
          state_d  = StRd;
        end
      end
      StRd: state_d = StChk;
      StChk: begin
        row_buf_d = row_rd_data;
        if (&row_rd_data) begin
          if (cnt_q != MaxCnt) cnt_d = cnt_q + 5'd1;
          advance = 1'b1;
        end else if (rd_ptr_q != wr_ptr_q) begin
          state_d = StWr;
        end else begin
          // Row already sits where it belongs; just claim the slot.
          wr_ptr_d = wr_ptr_q - 5'd1;
          advance  = 1'b1;
        end
      end
      StWr: begin
        wr_ptr_d = wr_ptr_q - 5'd1;
        advance  = 1'b1;
      end
      StFill: begin
        if (wr_ptr_q == 5'd0) state_d = StDone;
        else                  wr_ptr_d = wr_ptr_q - 5'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (rd_ptr_q == 5'd0) begin
        state_d = (cnt_d != 5'd0) ? StFill : StDone;
      end else begin
        rd_ptr_d = rd_ptr_q - 5'd1;
        state_d  = StRd;
      end
    end
  end

  always_comb begin
    row_addr    = rd_ptr_q;
    row_wr_en   = 1'b0;
    row_wr_data = '0;
    case (state_q)
      StWr: begin
        row_addr    = wr_ptr_q;
        row_wr_en   = 1'b1;
        row_wr_data = row_buf_q;
      end
      StFill: begin
        row_addr  = wr_ptr_q;
        row_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign lines      = done ? cnt_q : 5'd0;
  assign points_add = done ? score_points(cnt_q) : 20'd0;

endmodule

// File: tb/tb_line_clear_ctl.sv
// Table-driven and randomized sweeps of line_clear_ctl against a board-level reference model.
module tb_line_clear_ctl;

  localparam int Rows = 20;
  localparam int Cols = 10;
  localparam logic [9:0] Full = 10'h3FF;

  logic              pclk;
  logic              rst_n;
  logic              start;
  logic [4:0]        row_addr;
  logic [Cols-1:0]   row_rd_data;
  logic              row_wr_en;
  logic [Cols-1:0]   row_wr_data;
  logic              busy;
  logic              done;
  logic [4:0]        lines;
  logic [19:0]       points_add;

  line_clear_ctl dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .start       (start),
    .row_addr    (row_addr),
    .row_rd_data (row_rd_data),
    .row_wr_en   (row_wr_en),
    .row_wr_data (row_wr_data),
    .busy        (busy),
    .done        (done),
    .lines       (lines),
    .points_add  (points_add)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Board RAM with one-cycle read latency, plus write and done-pulse counters.
  logic [9:0]   mem [Rows];
  logic [199:0] preset;
  logic         load;
  logic         wr_clr;
  int           wr_cnt;
  int           done_cnt;

  always @(posedge pclk) begin
    if (load) begin
      for (int r = 0; r < Rows; r++) mem[r] <= preset[r*10 +: 10];
    end else if (row_wr_en && row_addr < 5'd20) begin
      mem[row_addr] <= row_wr_data;
    end
    if (row_addr < 5'd20) row_rd_data <= mem[row_addr];
    else                  row_rd_data <= '0;
    if (wr_clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (row_wr_en) wr_cnt <= wr_cnt + 1;
      if (done)      done_cnt <= done_cnt + 1;
    end
  end

  int vectors;
  int miscompares;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [199:0] put(input logic [199:0] b, input int r, input logic [9:0] v);
    logic [199:0] o;
    o = b;
    o[r*10 +: 10] = v;
    return o;
  endfunction

  function automatic int score(input int n);
    int tbl [5];
    tbl = '{0, 40, 100, 300, 1200};
    return tbl[(n > 4) ? 4 : n];
  endfunction

  // Survivors keep their top-to-bottom order and settle against the floor.
  function automatic void model(input logic [199:0] b, output logic [199:0] eb,
                                output int ln, output int mv);
    int kept [$];
    eb = '0;
    ln = 0;
    mv = 0;
    for (int r = Rows - 1; r >= 0; r--) begin
      if (b[r*10 +: 10] == Full) ln++;
      else kept.push_back(r);
    end
    foreach (kept[i]) begin
      eb[(Rows - 1 - i)*10 +: 10] = b[kept[i]*10 +: 10];
      if (kept[i] != Rows - 1 - i) mv++;
    end
  endfunction

  task automatic preload(input logic [199:0] b);
    preset = b;
    load   = 1'b1;
    wr_clr = 1'b1;
    tick();
    load   = 1'b0;
    wr_clr = 1'b0;
  endtask

  task automatic check_sweep(input string nm, input logic [199:0] b, input logic [199:0] eb,
                             input int el, input int ep, input int elat, input int ewr,
                             input int restart_at);
    int lat;
    preload(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (restart_at > 0 && lat == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
    end
    chk({nm, ".done_seen"}, int'(done), 1);
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".lines"}, int'(lines), el);
    chk({nm, ".points"}, int'(points_add), ep);
    chk({nm, ".writes"}, wr_cnt, ewr);
    for (int r = 0; r < Rows; r++)
      chk($sformatf("%s.row%0d", nm, r), int'(mem[r]), int'(eb[r*10 +: 10]));
    if (restart_at > 0) start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk({nm, ".done_pulses"}, done_cnt, 1);
    chk({nm, ".idle_after"}, int'(busy), 0);
  endtask

  typedef struct {
    string        name;
    logic [199:0] board;
    logic [199:0] exp_board;
    int           exp_lines;
    int           exp_points;
    int           exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [199:0] b;
    logic [199:0] eb;
    int           ln;
    int           mv;
    int           wr_at_rst;
    int           guard;

    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    load   = 1'b0;
    wr_clr = 1'b0;
    preset = '0;

    b = '0;
    vecs[0] = '{"empty", b, b, 0, 0, 41};
    vecs[1] = '{"row19", put(b, 19, Full), b, 1, 40, 61};
    b = '0;
    for (int r = 16; r < 20; r++) b = put(b, r, Full);
    b = put(b, 15, 10'h201);
    vecs[2] = '{"four", b, put('0, 19, 10'h201), 4, 1200, 61};
    b = put(put(put('0, 17, Full), 19, Full), 18, 10'h0F0);
    vecs[3] = '{"two", b, put('0, 19, 10'h0F0), 2, 100, 61};
    b = put(put(put(put('0, 19, Full), 18, Full), 17, Full), 16, 10'h155);
    vecs[4] = '{"three", b, put('0, 19, 10'h155), 3, 300, 61};
    b = '0;
    for (int r = 0; r < Rows; r++) b = put(b, r, Full);
    vecs[5] = '{"all_full", b, '0, 20, 1200, 61};
    vecs[6] = '{"top_full", put(put('0, 0, Full), 19, 10'h001), put('0, 19, 10'h001), 1, 40, 42};

    // Reset state, and reset beating a simultaneous start.
    tick();
    tick();
    chk("rst.row_addr", int'(row_addr), 0);
    chk("rst.row_wr_en", int'(row_wr_en), 0);
    chk("rst.row_wr_data", int'(row_wr_data), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.lines", int'(lines), 0);
    chk("rst.points", int'(points_add), 0);
    start = 1'b1;
    tick();
    chk("rst_vs_start.busy", int'(busy), 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_vs_start.busy_later", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      model(vecs[i].board, eb, ln, mv);
      check_sweep(vecs[i].name, vecs[i].board, vecs[i].exp_board, vecs[i].exp_lines,
                  vecs[i].exp_points, vecs[i].exp_lat, mv + ln, 0);
    end

    // Extra start pulses mid-sweep and during the done cycle.
    model(vecs[3].board, eb, ln, mv);
    check_sweep("restart", vecs[3].board, vecs[3].exp_board, 2, 100, 61, mv + ln, 5);

    // Reset while a shift write is on the bus.
    b = put(put('0, 19, Full), 10, 10'h0AA);
    preload(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!row_wr_en && guard < 100) begin
      tick();
      guard++;
    end
    chk("midrst.saw_write", int'(row_wr_en), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst.wr_en", int'(row_wr_en), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    wr_at_rst = wr_cnt;
    tick();
    tick();
    tick();
    chk("midrst.no_more_writes", wr_cnt, wr_at_rst);
    chk("midrst.no_done", done_cnt, 0);
    rst_n = 1'b1;
    tick();
    b = put(put(put('0, 19, Full), 12, Full), 5, 10'h3C3);
    model(b, eb, ln, mv);
    check_sweep("after_rst", b, eb, ln, score(ln), 2*Rows + mv + ln + 1, mv + ln, 0);

    for (int n = 0; n < 40; n++) begin
      b = '0;
      for (int r = 0; r < Rows; r++) begin
        if ($urandom_range(0, 2) == 0) b = put(b, r, Full);
        else                           b = put(b, r, 10'($urandom_range(0, 1022)));
      end
      model(b, eb, ln, mv);
      check_sweep($sformatf("rand%0d", n), b, eb, ln, score(ln), 2*Rows + mv + ln + 1,
                  mv + ln, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_clear_ctl.md
LINE_CLEAR_CTL -- requirements
Module: line_clear_ctl

Interface
REQ-001 SHALL have parameter BOARD_ROWS, default 20, board height in rows (row 0 top, row BOARD_ROWS-1 bottom).
REQ-002 SHALL have parameter BOARD_COLS, default 10, board width in cells (one bit per cell, 1 = occupied).
REQ-003 pclk  in  1  single clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse after a locked piece has been written to the board.
REQ-006 row_addr  out  5  board row address, shared by read and write.
REQ-007 row_rd_data  in  BOARD_COLS  row contents; synchronous read, valid the cycle after row_addr is presented.
REQ-008 row_wr_en  out  1  write strobe for row_addr.
REQ-009 row_wr_data  out  BOARD_COLS  data written when row_wr_en=1.
REQ-010 busy  out  1  high from the cycle after start is accepted through the done cycle; requesters stall piece spawn and drop while busy.
REQ-011 done  out  1  one-cycle pulse when the sweep is complete.
REQ-012 lines  out  5  full rows removed in the sweep; valid while done=1.
REQ-013 points_add  out  20  score increment; valid while done=1.

Function
REQ-014 The state machine SHALL use states IDLE, RD, CHK, WR, FILL and DONE.
REQ-015 IDLE: when start=1, SHALL load rd_ptr=wr_ptr=BOARD_ROWS-1 and cnt=0, then go to RD; start SHALL be ignored in all other states.
REQ-016 RD: SHALL drive row_addr=rd_ptr with row_wr_en=0, then go to CHK.
REQ-017 CHK: SHALL capture row_rd_data into row_buf.
REQ-018 CHK, full row (all BOARD_COLS bits set): SHALL increment cnt and keep wr_ptr.
REQ-019 CHK, non-full row with rd_ptr!=wr_ptr: SHALL go to WR.
REQ-020 CHK, non-full row with rd_ptr==wr_ptr: SHALL decrement wr_ptr and perform no write.
REQ-021 WR: SHALL drive row_addr=wr_ptr, row_wr_en=1 and row_wr_data=row_buf for exactly one cycle, then decrement wr_ptr.
REQ-022 After CHK or WR of row 0, SHALL go to FILL if cnt>0, else to DONE; otherwise SHALL decrement rd_ptr and go to RD.
REQ-023 FILL: SHALL write all-zero rows at wr_ptr down to 0, one row per cycle, then go to DONE.
REQ-024 DONE: done=1, busy=1, lines=cnt and points_add per REQ-025 for one cycle, then go to IDLE.
REQ-025 Score table SHALL be: 0 lines -> 0, 1 -> 40, 2 -> 100, 3 -> 300, 4 or more -> 1200.
REQ-026 row_wr_en SHALL be 0 in IDLE, RD, CHK and DONE; at most one write per cycle.
REQ-027 Outputs SHALL be driven from state and registers only, with no combinational path from row_rd_data or start.
REQ-028 cnt SHALL count to BOARD_ROWS without wrapping (all rows full gives lines=20).
REQ-029 Latency SHALL be 2 cycles per kept-in-place or removed row, 3 per moved row, plus 1 per FILL row, plus 1 DONE cycle.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE and set row_addr=0, row_wr_en=0, row_wr_data=0, busy=0, done=0, lines=0, points_add=0, cnt=0 and both pointers to 0.
REQ-031 Reset SHALL win over a simultaneous start.
REQ-032 Reset mid-sweep SHALL abort with no further writes; the board may be left partially shifted.

Structure
REQ-033 BOARD_ROWS, BOARD_COLS and the score table constants SHALL reside in shared package tetris_pkg, also used by fallen_blocks and draw_rect_ctl.
REQ-034 The block SHALL be a single module with no sub-module; the score lookup SHALL be a function in tetris_pkg.

Verification
REQ-035 Empty board, start at cycle k -> no writes, done at k+41, lines=0, points_add=0.
REQ-036 Row 19 full, rows 0-18 empty, start at k -> 19 shift writes and row 0 zero-filled; row 19 then holds former row 18; done at k+61, lines=1, points_add=40.
REQ-037 Rows 16-19 full, row 15=0x201, others 0 -> row 19=0x201 and rows 0-18=0; lines=4, points_add=1200.
REQ-038 Rows 17 and 19 full, row 18=0x0F0 -> row 19=0x0F0, rows 0-18=0; lines=2, points_add=100.
REQ-039 start pulsed again while busy -> ignored, exactly one done pulse.
REQ-040 rst_n=0 during WR -> next cycle row_wr_en=0, busy=0, done never asserted; a later start runs a full correct sweep.
